// File: rtl/selection_cursor_if.sv
// Front-panel bundle: raw buttons and item mask in, cursor state out.
// The cursor block is the slave; the panel/testbench side drives as master.
interface selection_cursor_if;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic        btn_sel;
  logic [11:0] possibleItems;
  logic [3:0]  SW1pointer;
  logic [3:0]  SW2pointer;
  logic        focus;
  logic        move_pulse;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_sel, possibleItems,
    input  SW1pointer, SW2pointer, focus, move_pulse
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_sel, possibleItems,
    output SW1pointer, SW2pointer, focus, move_pulse
  );
endinterface

// File: rtl/selection_cursor.sv
// Button front end (sync + debounce + rising-edge press) and the grid/list
// cursor FSM that walks the 3x4 grid skipping unavailable items.

module sc_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synced input disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) level_d = sync2_q;
      else                  cnt_d   = cnt_q + 1'b1;
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;
endmodule

module selection_cursor #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int N_ITEMS         = 12,
  parameter int N_NAMES         = 6
) (
  input  logic               clk,
  input  logic               rst,
  selection_cursor_if.slave  bus
);
  localparam int NUM_LANES = 5;
  localparam int B_SEL = 0, B_UP = 1, B_DOWN = 2, B_LEFT = 3, B_RIGHT = 4;

  // Steps are stored as positive offsets mod N_ITEMS so one adder serves all directions.
  localparam logic [4:0] STEP_RIGHT = 5'd1;
  localparam logic [4:0] STEP_LEFT  = 5'(N_ITEMS - 1);
  localparam logic [4:0] STEP_DOWN  = 5'd3;
  localparam logic [4:0] STEP_UP    = 5'(N_ITEMS - 3);
  localparam logic [3:0] NAME_LAST  = 4'(N_NAMES - 1);

  typedef enum logic {IDLE, SEARCH} state_e;

  logic [NUM_LANES-1:0] raw_btn, press;

  assign raw_btn = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up, bus.btn_sel};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_btn
    sc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw_btn[i]),
      .press (press[i])
    );
  end

  state_e     state_q, state_d;
  logic [3:0] sw1_q, sw1_d, sw2_q, sw2_d;
  logic [3:0] cand_q, cand_d, start_q, start_d;
  logic [4:0] step_q, step_d;
  logic       focus_q, focus_d, pulse_q, pulse_d;

  function automatic logic [3:0] fold(input logic [3:0] a, input logic [4:0] b);
    logic [4:0] s;
    s = {1'b0, a} + b;
    if (s >= 5'(N_ITEMS)) s = s - 5'(N_ITEMS);
    return s[3:0];
  endfunction

  always_comb begin
    state_d = state_q;
    sw1_d   = sw1_q;
    sw2_d   = sw2_q;
    cand_d  = cand_q;
    start_d = start_q;
    step_d  = step_q;
    focus_d = focus_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (press[B_SEL]) begin
          focus_d = ~focus_q;
          pulse_d = 1'b1;
        end else if (focus_q) begin
          if (press[B_UP]) begin
            sw2_d   = (sw2_q == 4'd0) ? NAME_LAST : sw2_q - 4'd1;
            pulse_d = 1'b1;
          end else if (press[B_DOWN]) begin
            sw2_d   = (sw2_q == NAME_LAST) ? 4'd0 : sw2_q + 4'd1;
            pulse_d = 1'b1;
          end
        end else if (|press[B_RIGHT:B_UP]) begin
          if      (press[B_UP])   step_d = STEP_UP;
          else if (press[B_DOWN]) step_d = STEP_DOWN;
          else if (press[B_LEFT]) step_d = STEP_LEFT;
          else                    step_d = STEP_RIGHT;
          start_d = sw1_q;
          cand_d  = fold(sw1_q, step_d);
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        // Back at the start means the whole ring was tried; stay put silently.
        if (cand_q == start_q) begin
          state_d = IDLE;
        end else if (bus.possibleItems[cand_q]) begin
          sw1_d   = cand_q;
          pulse_d = 1'b1;
          state_d = IDLE;
        end else begin
          cand_d = fold(cand_q, step_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sw1_q   <= '0;
      sw2_q   <= '0;
      cand_q  <= '0;
      start_q <= '0;
      step_q  <= '0;
      focus_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sw1_q   <= sw1_d;
      sw2_q   <= sw2_d;
      cand_q  <= cand_d;
      start_q <= start_d;
      step_q  <= step_d;
      focus_q <= focus_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus.SW1pointer = sw1_q;
  assign bus.SW2pointer = sw2_q;
  assign bus.focus      = focus_q;
  assign bus.move_pulse = pulse_q;
endmodule

// File: tb/tb_selection_cursor.sv
// Directed bench: button scripts push expected cursor states and arrival cycles;
// a negedge monitor pops one entry per move_pulse and flags any unexpected pulse.
module tb_selection_cursor;
  localparam int D = 4;
  localparam int LAT_LIST = 2 + D + 1;        // raw edge -> list/focus update
  localparam logic [4:0] M_SEL = 5'b00001, M_UP = 5'b00010, M_DOWN = 5'b00100,
                         M_LEFT = 5'b01000, M_RIGHT = 5'b10000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  selection_cursor_if bus ();
  selection_cursor #(.DEBOUNCE_CYCLES(D), .N_ITEMS(12), .N_NAMES(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] sw1;
    logic [3:0] sw2;
    logic       focus;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  initial forever @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  initial forever begin
    @(negedge clk);
    if (bus.move_pulse) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: cycle %0d sw1=%0d sw2=%0d focus=%0d",
                 cyc, bus.SW1pointer, bus.SW2pointer, bus.focus);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_sw1",   int'(bus.SW1pointer), int'(e.sw1));
        chk("pulse_sw2",   int'(bus.SW2pointer), int'(e.sw2));
        chk("pulse_focus", int'(bus.focus),      int'(e.focus));
        chk("pulse_cycle", cyc,                  e.cyc);
      end
    end
  end

  task automatic set_btn(input logic [4:0] m);
    {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up, bus.btn_sel} = m;
  endtask

  task automatic press_btn(input logic [4:0] m, input int hold, input bit exp_pulse,
                           input logic [3:0] e1, input logic [3:0] e2,
                           input logic ef, input int lat);
    exp_t e;
    @(negedge clk);
    if (exp_pulse) begin
      e.sw1 = e1; e.sw2 = e2; e.focus = ef; e.cyc = cyc + lat;
      sb.push_back(e);
    end
    set_btn(m);
    repeat (hold) @(negedge clk);
    set_btn(5'b0);
    repeat (30) @(negedge clk);
  endtask

  initial begin
    set_btn(5'b0);
    bus.possibleItems = 12'hFFF;
    repeat (3) @(negedge clk);
    chk("rst_sw1",   int'(bus.SW1pointer), 0);
    chk("rst_sw2",   int'(bus.SW2pointer), 0);
    chk("rst_focus", int'(bus.focus),      0);
    chk("rst_pulse", int'(bus.move_pulse), 0);
    rst = 1'b0;

    // 1: long hold gives a single move
    press_btn(M_RIGHT, 20, 1, 4'd1, 4'd0, 1'b0, LAT_LIST + 1);
    // 2: short glitch rejected
    press_btn(M_RIGHT, 3, 0, 4'd0, 4'd0, 1'b0, 0);
    chk("glitch_sw1", int'(bus.SW1pointer), 1);
    // 3: wraparound both directions
    press_btn(M_LEFT,  10, 1, 4'd0,  4'd0, 1'b0, LAT_LIST + 1);
    press_btn(M_LEFT,  10, 1, 4'd11, 4'd0, 1'b0, LAT_LIST + 1);
    press_btn(M_RIGHT, 10, 1, 4'd0,  4'd0, 1'b0, LAT_LIST + 1);
    press_btn(M_RIGHT, 10, 1, 4'd1,  4'd0, 1'b0, LAT_LIST + 1);
    press_btn(M_UP,    10, 1, 4'd10, 4'd0, 1'b0, LAT_LIST + 1);
    press_btn(M_RIGHT, 10, 1, 4'd11, 4'd0, 1'b0, LAT_LIST + 1);
    press_btn(M_RIGHT, 10, 1, 4'd0,  4'd0, 1'b0, LAT_LIST + 1);
    // 4: skipping unavailable items, and full loop with nothing else available
    bus.possibleItems = 12'h010;
    press_btn(M_RIGHT, 10, 1, 4'd4, 4'd0, 1'b0, LAT_LIST + 4);
    bus.possibleItems = 12'h011;
    press_btn(M_RIGHT, 10, 1, 4'd0, 4'd0, 1'b0, LAT_LIST + 8);
    bus.possibleItems = 12'h001;
    press_btn(M_RIGHT, 10, 0, 4'd0, 4'd0, 1'b0, 0);
    chk("loop_sw1", int'(bus.SW1pointer), 0);
    // 5: list focus
    press_btn(M_SEL,  10, 1, 4'd0, 4'd0, 1'b1, LAT_LIST);
    press_btn(M_UP,   10, 1, 4'd0, 4'd5, 1'b1, LAT_LIST);
    press_btn(M_DOWN, 10, 1, 4'd0, 4'd0, 1'b1, LAT_LIST);
    press_btn(M_DOWN, 10, 1, 4'd0, 4'd1, 1'b1, LAT_LIST);
    press_btn(M_LEFT, 10, 0, 4'd0, 4'd0, 1'b0, 0);
    chk("list_left_sw2", int'(bus.SW2pointer), 1);
    chk("list_left_sw1", int'(bus.SW1pointer), 0);
    press_btn(M_SEL, 10, 1, 4'd0, 4'd1, 1'b0, LAT_LIST);
    // 6: reach 7, then reset in the middle of a search
    bus.possibleItems = 12'hFFF;
    press_btn(M_DOWN,  10, 1, 4'd3, 4'd1, 1'b0, LAT_LIST + 1);
    press_btn(M_DOWN,  10, 1, 4'd6, 4'd1, 1'b0, LAT_LIST + 1);
    press_btn(M_RIGHT, 10, 1, 4'd7, 4'd1, 1'b0, LAT_LIST + 1);
    bus.possibleItems = 12'h001;
    @(negedge clk);
    set_btn(M_RIGHT);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    set_btn(5'b0);
    @(negedge clk);
    chk("midrst_sw1",   int'(bus.SW1pointer), 0);
    chk("midrst_sw2",   int'(bus.SW2pointer), 0);
    chk("midrst_focus", int'(bus.focus),      0);
    chk("midrst_pulse", int'(bus.move_pulse), 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    press_btn(M_SEL | M_UP, 10, 1, 4'd0, 4'd0, 1'b1, LAT_LIST);
    chk("final_sw2",    int'(bus.SW2pointer), 0);
    chk("sb_drained",   sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
